// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants for a 25 MHz pixel clock.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HELD      = 2'd2,
      REL_CHK   = 2'd3
   } btn_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 500_000;     // 20 ms
   localparam int DEF_REPEAT_EN       = 1;
   localparam int DEF_REPEAT_DELAY    = 12_500_000;  // 0.5 s
   localparam int DEF_REPEAT_PERIOD   = 5_000_000;   // 0.2 s
   localparam int DEF_CNT_W           = 24;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, bounce filter FSM with registered
// press pulse and debounced level, plus optional auto-repeat while held.
module debounce_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = DEF_REPEAT_EN,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic vgaclk,
   input  logic rst,
   input  logic btn,
   output logic pulse,
   output logic lvl
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   btn_state_t       state;
   logic             sync1;
   logic             s;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rcnt;
   logic             rep_later;  // 0 until the first repeat pulse of a press

   // NOTE: every register here, synchroniser included, uses <= so all
   // stages sample the values from before the edge.
   always_ff @(posedge vgaclk) begin
      if (rst) begin
         sync1     <= 1'b0;
         s         <= 1'b0;
         state     <= IDLE;
         cnt       <= '0;
         rcnt      <= '0;
         rep_later <= 1'b0;
         pulse     <= 1'b0;
         lvl       <= 1'b0;
      end else begin
         sync1 <= btn;
         s     <= sync1;
         pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (s) begin
                  state <= PRESS_CHK;
                  cnt   <= '0;
               end
            end
            PRESS_CHK: begin
               if (!s) begin
                  state <= IDLE;
               end else if (cnt == DEB_LAST) begin
                  state     <= HELD;
                  pulse     <= 1'b1;
                  lvl       <= 1'b1;
                  rcnt      <= '0;
                  rep_later <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               // A release candidate freezes rcnt so a glitch resumes the schedule.
               if (!s) begin
                  state <= REL_CHK;
                  cnt   <= '0;
               end else if (REPEAT_EN != 0) begin
                  if (rcnt == (rep_later ? PER_LAST : DLY_LAST)) begin
                     pulse     <= 1'b1;
                     rcnt      <= '0;
                     rep_later <= 1'b1;
                  end else begin
                     rcnt <= rcnt + 1'b1;
                  end
               end
            end
            REL_CHK: begin
               if (s) begin
                  state <= HELD;
               end else if (cnt == DEB_LAST) begin
                  state <= IDLE;
                  lvl   <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/btn_debounce.sv
// Two independent debounced button channels feeding the picture selector
// with single-cycle press pulses and debounced levels.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = DEF_REPEAT_EN,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic vgaclk,
   input  logic rst,
   input  logic btn1,
   input  logic btn2,
   output logic btn1_de,
   output logic btn2_de,
   output logic btn1_lvl,
   output logic btn2_lvl
);

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
   ) u_ch1 (
      .vgaclk (vgaclk),
      .rst    (rst),
      .btn    (btn1),
      .pulse  (btn1_de),
      .lvl    (btn1_lvl)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
   ) u_ch2 (
      .vgaclk (vgaclk),
      .rst    (rst),
      .btn    (btn2),
      .pulse  (btn2_de),
      .lvl    (btn2_lvl)
   );

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random button
// activity, compared every cycle against a run-length based reference model.
module tb_btn_debounce;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic vgaclk = 1'b0;
   logic rst    = 1'b1;
   logic btn1   = 1'b0;
   logic btn2   = 1'b0;
   logic de1, de2, lv1, lv2;
   logic nde1, nde2, nlv1, nlv2;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   always #5 vgaclk = ~vgaclk;

   btn_debounce #(
      .DEBOUNCE_CYCLES (D), .REPEAT_EN (1), .REPEAT_DELAY (RD),
      .REPEAT_PERIOD (RP), .CNT_W (8)
   ) dut (
      .vgaclk (vgaclk), .rst (rst), .btn1 (btn1), .btn2 (btn2),
      .btn1_de (de1), .btn2_de (de2), .btn1_lvl (lv1), .btn2_lvl (lv2)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (D), .REPEAT_EN (0), .REPEAT_DELAY (RD),
      .REPEAT_PERIOD (RP), .CNT_W (8)
   ) dut_nr (
      .vgaclk (vgaclk), .rst (rst), .btn1 (btn1), .btn2 (btn2),
      .btn1_de (nde1), .btn2_de (nde2), .btn1_lvl (nlv1), .btn2_lvl (nlv2)
   );

   // Reference: level flips after D+1 consecutive samples disagreeing with it;
   // repeat time accrues only on samples that agree with a settled high level.
   typedef struct {
      bit s1, s2, lvl, pulse, first;
      int run, hold;
   } chan_m_t;

   chan_m_t m[4];  // 0/1: dut btn1/btn2, 2/3: dut_nr btn1/btn2

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, edge_n, got, exp);
      end
   endtask

   task automatic model_edge(input int c, input bit b, input bit r, input bit rep_en);
      chan_m_t x;
      bit      smp;
      x = m[c];
      if (r) begin
         x.s1 = 0; x.s2 = 0; x.lvl = 0; x.pulse = 0; x.first = 1;
         x.run = 0; x.hold = 0;
      end else begin
         smp     = x.s2;
         x.pulse = 0;
         if (smp != x.lvl) begin
            x.run++;
            if (x.run == D + 1) begin
               x.lvl = smp;
               x.run = 0;
               if (smp) begin
                  x.pulse = 1;
                  x.hold  = 0;
                  x.first = 1;
               end
            end
         end else begin
            if (x.run == 0 && x.lvl && rep_en) begin
               x.hold++;
               if (x.hold == (x.first ? RD : RP)) begin
                  x.pulse = 1;
                  x.hold  = 0;
                  x.first = 0;
               end
            end
            x.run = 0;
         end
         x.s2 = x.s1;
         x.s1 = b;
      end
      m[c] = x;
   endtask

   task automatic step(input bit b1, input bit b2, input bit r);
      btn1 = b1;
      btn2 = b2;
      rst  = r;
      @(posedge vgaclk);
      model_edge(0, b1, r, 1'b1);
      model_edge(1, b2, r, 1'b1);
      model_edge(2, b1, r, 1'b0);
      model_edge(3, b2, r, 1'b0);
      #1;
      check("de1",     32'(de1),  32'(m[0].pulse));
      check("de2",     32'(de2),  32'(m[1].pulse));
      check("lvl1",    32'(lv1),  32'(m[0].lvl));
      check("lvl2",    32'(lv2),  32'(m[1].lvl));
      check("nr_de1",  32'(nde1), 32'(m[2].pulse));
      check("nr_de2",  32'(nde2), 32'(m[3].pulse));
      check("nr_lvl1", 32'(nlv1), 32'(m[2].lvl));
      check("nr_lvl2", 32'(nlv2), 32'(m[3].lvl));
      edge_n++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int first1, first2, rise1, fall1, cnt1, cnt2, cnt_nr, min_lvl, second, third;
      bit b1, b2;
      int hold1, hold2;

      for (int c = 0; c < 4; c++) begin
         m[c].s1 = 0; m[c].s2 = 0; m[c].lvl = 0; m[c].pulse = 0;
         m[c].first = 1; m[c].run = 0; m[c].hold = 0;
      end

      // Reset state
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
      check("rst_outs", {28'd0, de1, de2, lv1, lv2}, 32'd0);
      idle(4);

      // Clean press, then full release
      first1 = -1; rise1 = -1; cnt1 = 0; cnt2 = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (de1) begin cnt1++; if (first1 < 0) first1 = i; end
         if (de2) cnt2++;
         if (lv1 && rise1 < 0) rise1 = i;
      end
      check("press_edge", first1, 6);
      check("press_cnt",  cnt1, 1);
      check("lvl_rise",   rise1, 6);
      check("btn2_quiet", cnt2, 0);
      fall1 = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (!lv1 && fall1 < 0) fall1 = i;
      end
      check("lvl_fall", fall1, 6);

      // Bounce rejection: short pulse, then 2-cycle toggling
      cnt1 = 0; rise1 = 0;
      for (int i = 0; i < 13; i++) begin
         step(i < 3, 1'b0, 1'b0);
         cnt1 += de1; rise1 += lv1;
      end
      for (int i = 0; i < 40; i++) begin
         step(((i / 2) % 2) == 0, 1'b0, 1'b0);
         cnt1 += de1; rise1 += lv1;
      end
      idle(8);
      check("bounce_pulses", cnt1, 0);
      check("bounce_lvl",    rise1, 0);

      // Auto-repeat on btn2, with and without repeat enabled
      cnt2 = 0; cnt_nr = 0; second = -1; third = -1;
      for (int i = 0; i < 52; i++) begin
         step(1'b0, i < 40, 1'b0);
         if (de2) begin
            cnt2++;
            if (cnt2 == 2) second = i;
            if (cnt2 == 3) third = i;
         end
         cnt_nr += nde2;
      end
      check("rep_count",  cnt2, 10);
      check("rep_first",  second, 16);
      check("rep_second", third, 19);
      check("norep_cnt",  cnt_nr, 1);

      // Release glitch on btn1, then full release
      cnt_nr = 0; min_lvl = 1;
      for (int i = 0; i < 20; i++) begin
         step(!(i == 12 || i == 13), 1'b0, 1'b0);
         cnt_nr += nde1;
         if (i >= 6 && !lv1) min_lvl = 0;
      end
      check("glitch_pulses", cnt_nr, 1);
      check("glitch_lvl",    min_lvl, 1);
      fall1 = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (!lv1 && fall1 < 0) fall1 = i;
      end
      check("glitch_fall", fall1, 6);

      // Simultaneous press
      first1 = -1; first2 = -1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (de1 && first1 < 0) first1 = i;
         if (de2 && first2 < 0) first2 = i;
      end
      check("sim_de1", first1, 6);
      check("sim_de2", first2, 6);
      idle(12);

      // Reset during PRESS_CHK and during HELD with the button kept down
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("rst_press", {28'd0, de1, de2, lv1, lv2}, 32'd0);
      first1 = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (de1 && first1 < 0) first1 = i;
      end
      check("rst_press_again", first1, 6);
      step(1'b1, 1'b0, 1'b1);
      check("rst_held", {28'd0, de1, de2, lv1, lv2}, 32'd0);
      first1 = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (de1 && first1 < 0) first1 = i;
      end
      check("rst_held_again", first1, 6);
      idle(12);

      // Random button activity with occasional reset
      b1 = 0; b2 = 0; hold1 = 0; hold2 = 0;
      for (int i = 0; i < 2000; i++) begin
         if (hold1 == 0) begin
            b1 = ~b1;
            hold1 = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 7);
         end
         if (hold2 == 0) begin
            b2 = ~b2;
            hold2 = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 7);
         end
         hold1--; hold2--;
         step(b1, b2, $urandom_range(0, 149) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
